udp_payload_packer: RTL and testbench

UDP_PAYLOAD_PACKER -- requirements
Module: udp_payload_packer

---
 rtl/udp_payload_packer.sv | 145 ++++++++++++++
 tb/tb_udp_payload_packer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_payload_packer.sv
`default_nettype none
// ============================================================================
// udp_payload_packer : packs a byte stream big-endian into 64-bit UDP TX FIFO
// words and reports UDP/IP lengths once a packet has been written.
// Revision: 1.0
// ============================================================================
module udp_payload_packer #(
  parameter int         MAX_PAYLOAD = 1472,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic        wr_clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  input  logic        etx_full,
  output logic        wr_en,
  output logic [63:0] etx_din,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        tx_enable
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [63:0] PAD_WORD = {8{PAD_BYTE}};

  state_t      state;
  state_t      state_nx;
  logic [10:0] count;
  logic [2:0]  lane;
  logic [63:0] acc;
  logic [63:0] word;
  logic        pending;

  logic        accept;
  logic [10:0] count_nx;
  logic        pkt_end;
  logic        latch;
  logic [5:0]  shift;
  logic [63:0] acc_ins;

  assign accept   = byte_valid && byte_ready;
  assign count_nx = (state == IDLE) ? 11'd1 : count + 11'd1;
  assign pkt_end  = accept && (byte_last || (count_nx == MAX_CNT));
  assign latch    = accept && ((lane == 3'd7) || pkt_end);
  // lane 0 lands in the top byte, so the bit offset is (7 - lane) * 8
  assign shift    = {~lane, 3'b000};

  always_comb begin
    acc_ins             = acc;
    acc_ins[shift +: 8] = byte_data;
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    case (state)
      IDLE: begin
        byte_ready = !reset;
        if (accept) begin
          state_nx = pkt_end ? FLUSH : PACK;
        end
      end
      PACK: begin
        byte_ready = !reset && !pending;
        if (pkt_end) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (pending && !etx_full) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      count           <= 11'd0;
      lane            <= 3'd0;
      acc             <= PAD_WORD;
      word            <= 64'd0;
      pending         <= 1'b0;
      wr_en           <= 1'b0;
      etx_din         <= 64'd0;
      tx_enable       <= 1'b0;
      tx_data_length  <= 16'd0;
      tx_total_length <= 16'd0;
    end else begin
      wr_en     <= 1'b0;
      tx_enable <= 1'b0;

      if (pending && !etx_full) begin
        wr_en   <= 1'b1;
        etx_din <= word;
        pending <= 1'b0;
      end

      // Accept never coincides with pending, so the two updates cannot clash.
      if (accept) begin
        count <= count_nx;
        if (latch) begin
          word    <= acc_ins;
          pending <= 1'b1;
          acc     <= PAD_WORD;
          lane    <= 3'd0;
        end else begin
          acc  <= acc_ins;
          lane <= lane + 3'd1;
        end
      end

      if (state == DONE) begin
        tx_data_length  <= {5'd0, count} + 16'd8;
        tx_total_length <= {5'd0, count} + 16'd28;
        tx_enable       <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_payload_packer.sv
`default_nettype none
// ============================================================================
// tb_udp_payload_packer : directed + randomized bench with a packet-level model.
// Revision: 1.0
// ============================================================================
module tb_udp_payload_packer;

  localparam int MAX = 1472;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        etx_full;
  logic        wr_en;
  logic [63:0] etx_din;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        tx_enable;

  logic full_force = 1'b0;
  logic rand_full  = 1'b0;
  logic rand_bit   = 1'b0;
  logic gaps       = 1'b0;
  logic full_at_edge = 1'b0;
  logic prev_txen    = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0]  cur[$];
  logic [63:0] exp_words[$];
  logic [31:0] exp_len[$];
  logic [63:0] obs_words[$];
  logic [31:0] obs_len[$];

  assign etx_full = rand_full ? rand_bit : full_force;

  udp_payload_packer #(.MAX_PAYLOAD(MAX), .PAD_BYTE(8'h00)) dut (
    .wr_clk          (wr_clk),
    .reset           (reset),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_last       (byte_last),
    .byte_ready      (byte_ready),
    .etx_full        (etx_full),
    .wr_en           (wr_en),
    .etx_din         (etx_din),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .tx_enable       (tx_enable)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a packet is the bytes up to 'last' or MAX; it becomes
  // ceil(n/8) zero-padded big-endian words and one length pair.
  function automatic logic [63:0] pack8(int base);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < 8; i++)
      if (base + i < cur.size()) w[63 - 8*i -: 8] = cur[base + i];
    return w;
  endfunction

  function automatic void model_push(logic [7:0] d, logic last);
    int n;
    cur.push_back(d);
    n = cur.size();
    if (last || n == MAX) begin
      for (int b = 0; b < n; b += 8) exp_words.push_back(pack8(b));
      exp_len.push_back({16'(n + 8), 16'(n + 28)});
      cur.delete();
    end
  endfunction

  // Reset mid-packet: only completed words were written, the rest is lost.
  function automatic void model_abort();
    for (int b = 0; b + 8 <= cur.size(); b += 8) exp_words.push_back(pack8(b));
    cur.delete();
  endfunction

  always @(posedge wr_clk) full_at_edge <= etx_full;

  always @(negedge wr_clk) begin
    rand_bit <= ($urandom_range(0, 2) == 0);
    prev_txen <= tx_enable;
    if (!reset) begin
      if (wr_en) begin
        obs_words.push_back(etx_din);
        chk("wr_while_full", {63'd0, full_at_edge}, 64'd0);
      end
      if (tx_enable) begin
        obs_len.push_back({tx_data_length, tx_total_length});
        chk("tx_enable_single", {63'd0, prev_txen}, 64'd0);
      end
    end
  end

  int cyc;

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic last);
    logic rdy;
    logic ok = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      byte_valid = 1'b0;
      @(negedge wr_clk);
    end
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    for (int k = 0; k < 2000; k++) begin
      rdy = byte_ready;
      @(posedge wr_clk);
      cyc++;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge wr_clk);
    end
    @(negedge wr_clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (ok) model_push(d, last);
    else chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all(input string tag);
    int nw;
    int nl;
    for (int k = 0; k < 3000 && (obs_words.size() < exp_words.size() ||
                                 obs_len.size() < exp_len.size()); k++)
      @(negedge wr_clk);
    repeat (5) @(negedge wr_clk);
    chk({tag, "_nwords"}, 64'(obs_words.size()), 64'(exp_words.size()));
    chk({tag, "_npkts"}, 64'(obs_len.size()), 64'(exp_len.size()));
    nw = (obs_words.size() < exp_words.size()) ? obs_words.size() : exp_words.size();
    nl = (obs_len.size() < exp_len.size()) ? obs_len.size() : exp_len.size();
    for (int i = 0; i < nw; i++) chk({tag, "_word"}, obs_words[i], exp_words[i]);
    for (int i = 0; i < nl; i++) chk({tag, "_len"}, 64'(obs_len[i]), 64'(exp_len[i]));
  endtask

  task automatic clear_q();
    obs_words.delete();
    obs_len.delete();
    exp_words.delete();
    exp_len.delete();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_rst_ready"}, {63'd0, byte_ready}, 64'd0);
    chk({tag, "_rst_wr_en"}, {63'd0, wr_en}, 64'd0);
    chk({tag, "_rst_din"}, etx_din, 64'd0);
    chk({tag, "_rst_txen"}, {63'd0, tx_enable}, 64'd0);
    chk({tag, "_rst_lens"}, {32'd0, tx_data_length, tx_total_length}, 64'd0);
    @(negedge wr_clk);
    reset = 1'b0;
    #1;
    chk({tag, "_ready_after_rst"}, {63'd0, byte_ready}, 64'd1);
    @(negedge wr_clk);
  endtask

  initial begin
    string hello = "HELLO ALINX AX51INX 62\n\r";
    int n;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    byte_last  = 1'b0;
    cyc        = 0;
    repeat (3) @(negedge wr_clk);
    do_reset("init");

    // 24-byte packet, full throughput
    cyc = 0;
    for (int i = 0; i < 24; i++) send_byte(hello[i], i == 23);
    chk("hello_throughput", {63'd0, cyc <= 27}, 64'd1);
    check_all("hello");
    chk("hello_w0", obs_words[0], 64'h48454C4C4F20414C);
    chk("hello_lens", 64'(obs_len[0]), {32'd0, 16'd32, 16'd52});
    clear_q();

    // 5-byte partial word
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
    check_all("five");
    chk("five_w0", obs_words[0], 64'h0102030405000000);
    chk("five_lens", 64'(obs_len[0]), {32'd0, 16'd13, 16'd33});
    clear_q();

    // FIFO back-pressure right after the first word latches
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    full_force = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'd9;
    repeat (20) begin
      @(negedge wr_clk);
      chk("stall_wr_en", {63'd0, wr_en}, 64'd0);
      chk("stall_ready", {63'd0, byte_ready}, 64'd0);
    end
    full_force = 1'b0;
    @(negedge wr_clk);
    chk("stall_release_wr", {63'd0, wr_en}, 64'd1);
    chk("stall_release_din", etx_din, 64'h0102030405060708);
    for (int i = 9; i <= 12; i++) send_byte(8'(i), i == 12);
    check_all("stall");
    clear_q();

    // Random packets with random gaps and random back-pressure
    gaps      = 1'b1;
    rand_full = 1'b1;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1);
    end
    check_all("rand");
    clear_q();
    gaps      = 1'b0;
    rand_full = 1'b0;
    repeat (3) @(negedge wr_clk);

    // byte_last on the byte that also reaches MAX: one packet only
    for (int i = 0; i < MAX; i++) send_byte(8'($urandom), i == MAX - 1);
    check_all("max_last");
    clear_q();

    // 1500 bytes without last: split at MAX, remainder starts a new packet
    for (int i = 0; i < 1500; i++) send_byte(8'($urandom), 1'b0);
    model_abort();
    check_all("max_split");
    chk("max_split_lens", 64'(obs_len[0]), {32'd0, 16'd1480, 16'd1500});
    clear_q();
    do_reset("split");

    // Reset after 11 bytes drops the partial second word
    for (int i = 1; i <= 11; i++) send_byte(8'(i), 1'b0);
    repeat (3) @(negedge wr_clk);
    do_reset("mid");
    model_abort();
    repeat (10) begin
      @(negedge wr_clk);
      chk("post_rst_no_wr", {63'd0, wr_en}, 64'd0);
    end
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), i == 7);
    check_all("mid");
    chk("mid_lens", 64'(obs_len[0]), {32'd0, 16'd16, 16'd36});
    clear_q();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
